// File: rtl/keypad_scan_ctl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// keypad_scan_ctl
//   Scans a ROW_NUM x COL_NUM matrix keypad.
//   - Walks a one-cold, active-low strobe across the columns.
//   - Samples the synchronized active-low row lines once per column dwell.
//   - Debounces the per-scan key candidate across whole scans.
//   - Reports accepted keys as an index plus a one-cycle valid pulse.
//
// Ports
//   clk        in   system clock, single domain
//   rst_n      in   synchronous, active-low reset
//   row_n      in   [ROW_NUM-1:0] keypad rows, active-low, asynchronous to clk
//   col_n      out  [COL_NUM-1:0] column strobe, active-low, exactly one bit low
//   key_code   out  [3:0] accepted key index = row*COL_NUM + col
//   key_valid  out  one-cycle pulse when a key is accepted (or auto-repeats)
//   key_down   out  debounced "key held" level
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, a held key re-pulses key_valid every
//                     REPEAT_SCANS full scans. Otherwise REPEAT_SCANS is ignored.
// -----------------------------------------------------------------------------
module keypad_scan_ctl #(
  parameter int unsigned COL_NUM        = 4,
  parameter int unsigned ROW_NUM        = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ROW_NUM-1:0] row_n,
  output logic [COL_NUM-1:0] col_n,
  output logic [3:0]         key_code,
  output logic               key_valid,
  output logic               key_down
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = (COL_NUM  > 1) ? $clog2(COL_NUM)  : 1;
  localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COL_NUM - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  // Per-scan key candidate; none=1 covers both "no key" and "multi-key/ghost".
  typedef struct packed {
    logic       none;
    logic [3:0] idx;
  } cand_t;

  localparam cand_t CAND_NONE = '{none: 1'b1, idx: 4'd0};

  // Row synchronizer
  logic [ROW_NUM-1:0] row_s1_q, row_s2_q;

  // Scan timing
  logic [DW-1:0]      dwell_q;
  logic [CW-1:0]      col_q;
  logic [COL_NUM-1:0] col_n_q;

  // Snapshot accumulators for the scan in progress
  logic [1:0] acc_cnt_q;
  logic [3:0] acc_idx_q;

  // Completed scan candidate and debounce history
  cand_t      cand_q;
  logic       scan_done_q;
  cand_t      prev_cand_q;
  logic [SW-1:0] stable_q;

  // Registered outputs
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_down_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep_q;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic       sample;
  logic       col_last;
  logic [1:0] col_hits;
  logic [3:0] hit_idx;
  logic [2:0] cnt_sum;
  logic [1:0] scan_cnt_d;
  logic [3:0] scan_idx_d;

  assign sample   = (dwell_q == DWELL_LAST);
  assign col_last = (col_q == COL_LAST);

  // Pressed rows in the active column: saturating count plus lowest row index.
  always_comb begin
    col_hits = 2'd0;
    hit_idx  = 4'd0;
    for (int unsigned r = 0; r < ROW_NUM; r++) begin
      if (!row_s2_q[r]) begin
        if (col_hits == 2'd0) hit_idx = 4'(r * COL_NUM) + 4'(col_q);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  // Merge into the running snapshot. Columns are visited in ascending order,
  // so the first hit recorded is the lowest column, then the lowest row.
  always_comb begin
    cnt_sum    = {1'b0, acc_cnt_q} + {1'b0, col_hits};
    scan_cnt_d = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    scan_idx_d = (acc_cnt_q == 2'd0 && col_hits != 2'd0) ? hit_idx : acc_idx_q;
  end

  // Debounce step, evaluated in the cycle after a scan completes.
  logic          same;
  logic [SW-1:0] stable_d;
  logic          differs;
  logic          accept;

  always_comb begin
    same     = (cand_q == prev_cand_q);
    stable_d = SW'(1);
    if (same) stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
    // Only the transition into STABLE_MAX can accept, never a saturated hold.
    differs  = cand_q.none ? key_down_q
                           : (!key_down_q || (key_code_q != cand_q.idx));
    accept   = (stable_d == STABLE_MAX) && (stable_q != STABLE_MAX) && differs;
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      dwell_q     <= '0;
      col_q       <= '0;
      col_n_q     <= ~COL_NUM'(1);
      acc_cnt_q   <= '0;
      acc_idx_q   <= '0;
      cand_q      <= CAND_NONE;
      scan_done_q <= 1'b0;
      prev_cand_q <= CAND_NONE;
      stable_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;

      dwell_q <= sample ? '0 : dwell_q + DW'(1);

      if (sample) begin
        col_q   <= col_last ? '0 : col_q + CW'(1);
        col_n_q <= {col_n_q[COL_NUM-2:0], col_n_q[COL_NUM-1]};
        if (col_last) begin
          cand_q.none <= (scan_cnt_d != 2'd1);
          cand_q.idx  <= (scan_cnt_d == 2'd1) ? scan_idx_d : 4'd0;
          acc_cnt_q   <= '0;
          acc_idx_q   <= '0;
        end else begin
          acc_cnt_q <= scan_cnt_d;
          acc_idx_q <= scan_idx_d;
        end
      end

      scan_done_q <= sample && col_last;
      key_valid_q <= 1'b0;

      if (scan_done_q) begin
        prev_cand_q <= cand_q;
        stable_q    <= stable_d;
        if (accept) begin
          key_down_q <= !cand_q.none;
          if (!cand_q.none) begin
            key_code_q  <= cand_q.idx;
            key_valid_q <= 1'b1;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat only while the same debounced key is still seen each scan.
        if (accept || !key_down_q || cand_q.none || (cand_q.idx != key_code_q)) begin
          rep_q <= '0;
        end else if (rep_q == RPT_LAST) begin
          rep_q       <= '0;
          key_valid_q <= 1'b1;
        end else begin
          rep_q <= rep_q + RW'(1);
        end
`endif
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_ctl.sv
`timescale 1ns/1ps
// Directed bench for keypad_scan_ctl with SCAN_DIV=4, DEBOUNCE_SCANS=3,
// REPEAT_SCANS=5 (16 clk per full scan). A behavioural keypad drives row_n
// from the active column and the set of held keys.
module tb_keypad_scan_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] pressed = '0;

  int cyc = 0;
  int pulse_cnt = 0;
  int consec = 0;
  logic prev_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int p;

  keypad_scan_ctl #(
    .COL_NUM(4),
    .ROW_NUM(4),
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_n(row_n),
    .col_n(col_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Keypad: a held key pulls its row low while its column is strobed.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < 4; c++)
      if (col_n[c] === 1'b0)
        for (int r = 0; r < 4; r++)
          if (pressed[r*4 + c]) row_n[r] = 1'b0;
  end

  // Edge counter since last reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      if (prev_valid) consec <= consec + 1;
    end
    prev_valid <= (key_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return on the falling edge after posedge number n.
  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset and column rotation
    do_reset();
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    wait_to(4);
    chk("col_after4", col_n, 4'b1101);
    wait_to(16);
    chk("col_after16", col_n, 4'b1110);

    // 2: key 6 (row 1, col 2) held from scan 1; accepted at end of scan 3
    pressed = 16'h0040;
    p = pulse_cnt;
    wait_to(64);
    chk("k6_before_valid", key_valid, 1'b0);
    chk("k6_before_down", key_down, 1'b0);
    wait_to(65);
    chk("k6_valid", key_valid, 1'b1);
    chk("k6_code", key_code, 4'd6);
    chk("k6_down", key_down, 1'b1);
    wait_to(66);
    chk("k6_valid_one_cycle", key_valid, 1'b0);
    wait_to(144);
    chk("k6_single_pulse", pulse_cnt - p, 1);

    // 5a: release key 6; three clean scans to drop key_down, no pulse
    pressed = '0;
    wait_to(146);
    p = pulse_cnt;
    wait_to(192);
    chk("rel_down_held", key_down, 1'b1);
    wait_to(193);
    chk("rel_down", key_down, 1'b0);
    chk("rel_code_kept", key_code, 4'd6);
    chk("rel_no_valid", key_valid, 1'b0);
    wait_to(200);
    chk("rel_no_pulse", pulse_cnt - p, 0);

    // 3: bounce, one scan pressed then one released, 10 times
    wait_to(208);
    p = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed = 16'h0040;
      wait_to(208 + 32*i + 16);
      chk("bounce_down_a", key_down, 1'b0);
      pressed = '0;
      wait_to(208 + 32*i + 32);
      chk("bounce_down_b", key_down, 1'b0);
    end
    chk("bounce_no_pulse", pulse_cnt - p, 0);

    // 4: keys 0 and 5 together, then release key 0
    pressed = 16'h0021;
    p = pulse_cnt;
    wait_to(608);
    chk("multi_no_pulse", pulse_cnt - p, 0);
    chk("multi_down", key_down, 1'b0);
    pressed = 16'h0020;
    wait_to(656);
    chk("k5_before_valid", key_valid, 1'b0);
    wait_to(657);
    chk("k5_valid", key_valid, 1'b1);
    chk("k5_code", key_code, 4'd5);
    chk("k5_down", key_down, 1'b1);

    // 5b: release, then reset midway through debouncing a new press
    wait_to(672);
    pressed = '0;
    wait_to(720);
    pressed = 16'h0040;
    wait_to(721);
    chk("k5_rel_down", key_down, 1'b0);
    chk("k5_rel_code", key_code, 4'd5);
    wait_to(760);
    do_reset();
    p = pulse_cnt;
    chk("mid_rst_col_n", col_n, 4'b1110);
    chk("mid_rst_code", key_code, 4'd0);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_down", key_down, 1'b0);
    wait_to(48);
    chk("post_rst_no_early", pulse_cnt - p, 0);
    chk("post_rst_valid_low", key_valid, 1'b0);
    wait_to(49);
    chk("post_rst_valid", key_valid, 1'b1);
    chk("post_rst_code", key_code, 4'd6);
    chk("post_rst_down", key_down, 1'b1);

`ifdef KEYPAD_REPEAT_EN
    // 6: auto-repeat of key 9 (row 2, col 1) held for 20 scans
    pressed = '0;
    do_reset();
    pressed = 16'h0200;
    p = pulse_cnt;
    wait_to(48);
    chk("rpt_before", key_valid, 1'b0);
    wait_to(49);
    chk("rpt_first", key_valid, 1'b1);
    chk("rpt_first_code", key_code, 4'd9);
    wait_to(128);
    chk("rpt_gap", key_valid, 1'b0);
    wait_to(129);
    chk("rpt_2", key_valid, 1'b1);
    chk("rpt_2_code", key_code, 4'd9);
    wait_to(209);
    chk("rpt_3", key_valid, 1'b1);
    chk("rpt_3_code", key_code, 4'd9);
    wait_to(289);
    chk("rpt_4", key_valid, 1'b1);
    chk("rpt_4_code", key_code, 4'd9);
    wait_to(322);
    chk("rpt_count", pulse_cnt - p, 4);
`else
    // Held key must not re-pulse without the repeat option.
    wait_to(177);
    chk("no_repeat", pulse_cnt - p, 1);
    chk("no_repeat_down", key_down, 1'b1);
`endif

    chk("no_consecutive_valid", consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
